// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defines for the fetch-stage program-counter generator.
// Holds the control-level encodings (chip enable, flush, stall, branch, reset),
// the default reset vector, and the next-pc source selector used by pc_gen.
// No ports; imported by pc_gen_if, pc_redirect_buf and pc_gen.
package pc_gen_pkg;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Flush       = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic DoBranch    = 1'b1;
  localparam logic RstEnable   = 1'b1;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // Where the next fetch address comes from on a given edge.
  typedef enum logic [2:0] {
    SrcHold,
    SrcFlush,
    SrcBranch,
    SrcBuffer,
    SrcSeq
  } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between the pipeline control unit / decode
// (master) and the program-counter generator (slave).
//   stall              master->slave  STALL_W  stall vector, bit 0 = fetch stall
//   flush              master->slave  1        exception/flush redirect
//   new_pc             master->slave  ADDR_W   flush target
//   branch_flag_i      master->slave  1        decode-stage taken branch/jump
//   branch_addr_i      master->slave  ADDR_W   branch/jump target
//   pc                 slave->master  ADDR_W   current fetch address
//   ce                 slave->master  1        instruction-memory chip enable
//   redirect_pending_o slave->master  1        redirect buffer holds a branch
//   misalign_o         slave->master  1        pc not instruction-aligned
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_addr_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redirect_pending_o;
  logic               misalign_o;

  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_addr_i,
    input  pc, ce, redirect_pending_o, misalign_o
  );

  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_addr_i,
    output pc, ce, redirect_pending_o, misalign_o
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry redirect buffer (valid bit plus address) that
// holds a decode-stage branch which arrived while fetch was stalled.
//   clk        in   clock
//   rst        in   asynchronous active-high reset (buffer empties)
//   capture_i  in   load addr_i and mark valid
//   clear_i    in   drop the entry; wins over capture_i
//   addr_i     in   branch target to hold
//   valid_o    out  entry is valid
//   addr_o     out  held branch target
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;

  // The address is only meaningful while valid_q is set, so a clear leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage. Produces the fetch
// address and the instruction-memory chip enable. A branch from decode that
// arrives while fetch is stalled is parked in pc_redirect_buf and applied on
// the first unstalled edge.
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  pc_gen_if.slave  stall/flush/new_pc/branch in, pc/ce/pending/misalign out
// Parameters: ADDR_W, RESET_PC, INST_BYTES (power of two), STALL_W.
// Optional feature macro: PC_GEN_MISALIGN_CHECK_EN
//   defined   - targets load unmodified, misalign_o flags unaligned pc
//   undefined - targets are forced aligned, misalign_o tied to 0
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
  parameter int              INST_BYTES = 4,
  parameter int              STALL_W    = 6
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  // Mask of the byte-offset bits inside one instruction.
  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(INST_BYTES - 1);

  logic              ce_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  pc_src_e           pcSrc;
  logic              bufCapture;
  logic              bufClear;
  logic              bufValid;
  logic [ADDR_W-1:0] bufAddr;

  // Only the fetch stall bit matters here; the rest of the vector belongs to later stages.
  logic unusedStall;
  assign unusedStall = ^bus.stall[STALL_W-1:1];

  function automatic logic [ADDR_W-1:0] loadTarget(input logic [ADDR_W-1:0] target);
`ifdef PC_GEN_MISALIGN_CHECK_EN
    return target;
`else
    return target & ~LowMask;
`endif
  endfunction

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .capture_i(bufCapture),
    .clear_i  (bufClear),
    .addr_i   (bus.branch_addr_i),
    .valid_o  (bufValid),
    .addr_o   (bufAddr)
  );

  // Redirect priority: flush, then stall (capturing any branch), then a live
  // branch, then the buffered branch, then sequential fetch. Nothing moves
  // until the chip enable is up.
  always_comb begin
    pcSrc      = SrcHold;
    bufCapture = 1'b0;
    bufClear   = 1'b0;
    if (ce_q == ChipEnable) begin
      if (bus.flush == Flush) begin
        pcSrc    = SrcFlush;
        bufClear = 1'b1;
      end else begin
        case (bus.stall[0])
          Stop: begin
            bufCapture = (bus.branch_flag_i == DoBranch);
          end
          NoStop: begin
            if (bus.branch_flag_i == DoBranch) begin
              pcSrc    = SrcBranch;
              bufClear = 1'b1;
            end else if (bufValid) begin
              pcSrc    = SrcBuffer;
              bufClear = 1'b1;
            end else begin
              pcSrc = SrcSeq;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (pcSrc)
      SrcFlush:  pc_d = loadTarget(bus.new_pc);
      SrcBranch: pc_d = loadTarget(bus.branch_addr_i);
      SrcBuffer: pc_d = loadTarget(bufAddr);
      SrcSeq:    pc_d = pc_q + ADDR_W'(INST_BYTES);
      default:   pc_d = pc_q;
    endcase
  end

  // ce rises on the first edge after reset releases; pc cannot move on that
  // same edge because pcSrc is still SrcHold while ce_q is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      ce_q <= ChipDisable;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= ChipEnable;
      pc_q <= pc_d;
    end
  end

  assign bus.pc                 = pc_q;
  assign bus.ce                 = ce_q;
  assign bus.redirect_pending_o = bufValid;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  assign bus.misalign_o = (ce_q == ChipEnable) && ((pc_q & LowMask) != '0);
`else
  assign bus.misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. A behavioural model tracks the
// expected pc/ce/buffer state from the redirect rules; a negedge process
// compares every cycle, and directed steps pin hand-computed values.
module tb_pc_gen;

  localparam int          ADDR_W     = 32;
  localparam int          INST_BYTES = 4;
  localparam int          STALL_W    = 6;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

  pc_gen #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RESET_PC),
    .INST_BYTES(INST_BYTES),
    .STALL_W   (STALL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic        mCe;
  logic [31:0] mPc;
  logic        mBufValid;
  logic [31:0] mBufAddr;

  function automatic logic [31:0] modelLoad(input logic [31:0] target);
`ifdef PC_GEN_MISALIGN_CHECK_EN
    return target;
`else
    return target - (target % INST_BYTES);
`endif
  endfunction

  function automatic logic modelMisalign();
`ifdef PC_GEN_MISALIGN_CHECK_EN
    return mCe && ((mPc % INST_BYTES) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Behavioural model of the redirect rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCe       <= 1'b0;
      mPc       <= RESET_PC;
      mBufValid <= 1'b0;
      mBufAddr  <= '0;
    end else begin
      mCe <= 1'b1;
      if (mCe) begin
        if (bus.flush) begin
          mPc       <= modelLoad(bus.new_pc);
          mBufValid <= 1'b0;
        end else if (bus.stall[0]) begin
          if (bus.branch_flag_i) begin
            mBufValid <= 1'b1;
            mBufAddr  <= bus.branch_addr_i;
          end
        end else if (bus.branch_flag_i) begin
          mPc       <= modelLoad(bus.branch_addr_i);
          mBufValid <= 1'b0;
        end else if (mBufValid) begin
          mPc       <= modelLoad(mBufAddr);
          mBufValid <= 1'b0;
        end else begin
          mPc <= mPc + INST_BYTES;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("cyc_pc", bus.pc, mPc);
    checkOutput("cyc_ce", 32'(bus.ce), 32'(mCe));
    checkOutput("cyc_pending", 32'(bus.redirect_pending_o), 32'(mBufValid));
    checkOutput("cyc_misalign", 32'(bus.misalign_o), 32'(modelMisalign()));
  end

  task automatic applyStimulus(input logic [STALL_W-1:0] stallV, input logic fl, input logic [31:0] npc,
                               input logic br, input logic [31:0] baddr);
    bus.stall         = stallV;
    bus.flush         = fl;
    bus.new_pc        = npc;
    bus.branch_flag_i = br;
    bus.branch_addr_i = baddr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus('0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.stall         = '0;
    bus.flush         = 1'b0;
    bus.new_pc        = '0;
    bus.branch_flag_i = 1'b0;
    bus.branch_addr_i = '0;
    rst = 1'b1;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_ce", 32'(bus.ce), 32'h0);
      checkOutput("rst_pc", bus.pc, 32'h0);
    end
    rst = 1'b0;

    // First edge after release: redirect requests ignored while ce is still low
    applyStimulus(6'b000001, 1'b1, 32'h700, 1'b1, 32'h900);
    checkOutput("rel_ce", 32'(bus.ce), 32'h1);
    checkOutput("rel_pc", bus.pc, 32'h0);
    checkOutput("rel_pending", 32'(bus.redirect_pending_o), 32'h0);
    applyStimulus(6'b111110, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("seq_pc4", bus.pc, 32'h4);
    idle();
    checkOutput("seq_pc8", bus.pc, 32'h8);
    idle();
    idle();
    checkOutput("seq_pc10", bus.pc, 32'h10);

    // Stalled branch, buffered then applied
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b1, 32'h80);
    checkOutput("stall_pc", bus.pc, 32'h10);
    checkOutput("stall_pending", 32'(bus.redirect_pending_o), 32'h1);
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("stall_hold_pc", bus.pc, 32'h10);
    idle();
    checkOutput("unstall_pc", bus.pc, 32'h80);
    checkOutput("unstall_pending", 32'(bus.redirect_pending_o), 32'h0);
    idle();
    checkOutput("after_buf_pc", bus.pc, 32'h84);

    // Flush beats stall and empties the buffer
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b1, 32'h80);
    checkOutput("cap2_pending", 32'(bus.redirect_pending_o), 32'h1);
    applyStimulus(6'b000001, 1'b1, 32'h200, 1'b0, 32'h0);
    checkOutput("flush_pc", bus.pc, 32'h200);
    checkOutput("flush_pending", 32'(bus.redirect_pending_o), 32'h0);
    idle();
    checkOutput("flush_next_pc", bus.pc, 32'h204);

    // Live branch beats buffered one
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b1, 32'h80);
    applyStimulus(6'b000000, 1'b0, 32'h0, 1'b1, 32'h300);
    checkOutput("live_pc", bus.pc, 32'h300);
    checkOutput("live_pending", 32'(bus.redirect_pending_o), 32'h0);
    idle();
    checkOutput("live_next_pc", bus.pc, 32'h304);

    // Flush and capture on the same edge
    applyStimulus(6'b000001, 1'b1, 32'h400, 1'b1, 32'h500);
    checkOutput("flushcap_pc", bus.pc, 32'h400);
    checkOutput("flushcap_pending", 32'(bus.redirect_pending_o), 32'h0);

    // Wrap at the top of the address space
    applyStimulus(6'b000000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    checkOutput("wrap_top_pc", bus.pc, 32'hFFFF_FFFC);
    idle();
    checkOutput("wrap_pc", bus.pc, 32'h0);

    // Misaligned flush target and misaligned buffered branch
    applyStimulus(6'b000000, 1'b1, 32'h102, 1'b0, 32'h0);
`ifdef PC_GEN_MISALIGN_CHECK_EN
    checkOutput("mis_pc", bus.pc, 32'h102);
    checkOutput("mis_flag", 32'(bus.misalign_o), 32'h1);
    idle();
    checkOutput("mis_inc_pc", bus.pc, 32'h106);
`else
    checkOutput("mis_pc", bus.pc, 32'h100);
    checkOutput("mis_flag", 32'(bus.misalign_o), 32'h0);
    idle();
    checkOutput("mis_inc_pc", bus.pc, 32'h104);
`endif
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b1, 32'h333);
    idle();
`ifdef PC_GEN_MISALIGN_CHECK_EN
    checkOutput("mis_buf_pc", bus.pc, 32'h333);
`else
    checkOutput("mis_buf_pc", bus.pc, 32'h330);
`endif
    applyStimulus(6'b000000, 1'b0, 32'h0, 1'b1, 32'h2A3);
`ifdef PC_GEN_MISALIGN_CHECK_EN
    checkOutput("mis_br_pc", bus.pc, 32'h2A3);
`else
    checkOutput("mis_br_pc", bus.pc, 32'h2A0);
`endif

    // Asynchronous reset between edges while the buffer is valid
    applyStimulus(6'b000001, 1'b0, 32'h0, 1'b1, 32'h80);
    checkOutput("pre_rst_pending", 32'(bus.redirect_pending_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_pc", bus.pc, RESET_PC);
    checkOutput("async_ce", 32'(bus.ce), 32'h0);
    checkOutput("async_pending", 32'(bus.redirect_pending_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    checkOutput("rerel_ce", 32'(bus.ce), 32'h1);
    checkOutput("rerel_pc", bus.pc, 32'h0);
    idle();
    checkOutput("rerel_pc4", bus.pc, 32'h4);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
